// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the next-PC redirect controller: defaults, redirect
// source codes, fence sequencer states and hazard stall codes.
package pc_redirect_ctrl_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h8000_0000;
    localparam int          DRAIN_MAX_DEF    = 64;

    typedef enum logic [2:0] {
        SRC_SEQ        = 3'd0,
        SRC_TRAP       = 3'd1,
        SRC_MISPREDICT = 3'd2,
        SRC_BRANCH     = 3'd3,
        SRC_JUMP       = 3'd4,
        SRC_FENCE      = 3'd5,
        SRC_PEND       = 3'd6
    } redirect_src_e;

    typedef enum logic [1:0] {
        FENCE_IDLE   = 2'd0,
        FENCE_DRAIN  = 2'd1,
        FENCE_RESUME = 2'd2
    } fence_state_e;

    // The hazard unit ORs these reasons together to form stall_fetch.
    localparam logic [1:0] STALL_EARLY = 2'b01;
    localparam logic [1:0] STALL_MMU   = 2'b10;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Bundle between the pipeline (hazard/EX/MEM/CSR/decode) and the redirect
// controller that drives the PC register and front-end flushes.
interface pc_redirect_ctrl_if;
    // pc_we is the only "valid": pc_next is consumed by the PC register on every
    // clock where pc_we=1; there is no ready, stall_fetch=1 is the backpressure.
    logic [31:0] pc_cur;
    logic        stall_fetch;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        mispredict_valid;
    logic [31:0] mispredict_pc;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_offset;
    logic        fence_req;
    logic        pipe_empty;
    logic [31:0] pc_next;
    logic        pc_we;
    logic        flush_front;
    logic        flush_ex;
    logic        fence_busy;
    logic        fence_timeout;
    logic [2:0]  redirect_src;

    modport master (
        output pc_cur, stall_fetch, trap_valid, trap_target, mispredict_valid,
               mispredict_pc, branch_valid, branch_target, jump_valid,
               jump_offset, fence_req, pipe_empty,
        input  pc_next, pc_we, flush_front, flush_ex, fence_busy,
               fence_timeout, redirect_src
    );

    modport slave (
        input  pc_cur, stall_fetch, trap_valid, trap_target, mispredict_valid,
               mispredict_pc, branch_valid, branch_target, jump_valid,
               jump_offset, fence_req, pipe_empty,
        output pc_next, pc_we, flush_front, flush_ex, fence_busy,
               fence_timeout, redirect_src
    );
endinterface

// File: rtl/pc_fence_seq.sv
// Fence drain/resume sequencer: waits for an empty pipeline (or a timeout),
// then holds RESUME until the restart PC is written.
module pc_fence_seq
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic         i_pipe_empty,
    input  logic         i_resume_wr,
    output fence_state_e o_state,
    output logic         o_busy,
    output logic         o_timeout
);
    fence_state_e r_state;
    fence_state_e w_state_nx;
    logic [7:0]   r_cnt;
    logic [7:0]   w_cnt_nx;
    logic         w_limit;

    assign w_limit = (r_cnt == 8'(DRAIN_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FENCE_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        o_timeout  = 1'b0;
        case (r_state)
            FENCE_IDLE: begin
                if (i_start) begin
                    w_state_nx = FENCE_DRAIN;
                    w_cnt_nx   = '0;
                end
            end
            FENCE_DRAIN: begin
                w_cnt_nx = r_cnt + 8'd1;
                if (i_abort) begin
                    w_state_nx = FENCE_IDLE;
                end else if (i_pipe_empty) begin
                    w_state_nx = FENCE_RESUME;
                end else if (w_limit) begin
                    w_state_nx = FENCE_RESUME;
                    o_timeout  = 1'b1;
                end
            end
            FENCE_RESUME: begin
                if (i_abort || i_resume_wr) w_state_nx = FENCE_IDLE;
            end
            default: w_state_nx = FENCE_IDLE;
        endcase
    end

    assign o_state = r_state;
    assign o_busy  = (r_state == FENCE_DRAIN);
endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC arbiter for the fetch stage. Optional PC_REDIRECT_PERF_EN adds
// saturating redirect/drain performance counters as extra output ports.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int          DRAIN_MAX    = DRAIN_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pc_redirect_ctrl_if.slave bus
`ifdef PC_REDIRECT_PERF_EN
    ,
    output logic [31:0]       perf_trap,
    output logic [31:0]       perf_mispredict,
    output logic [31:0]       perf_branch,
    output logic [31:0]       perf_jump,
    output logic [31:0]       perf_fence_cycles
`endif
);
    logic          r_pend_valid;
    logic [31:0]   r_pend_target;
    logic          w_stall;
    logic          w_late;
    logic [31:0]   w_late_tgt;
    redirect_src_e w_late_src;
    logic [31:0]   w_seq_pc;
    logic [31:0]   w_jump_tgt;
    logic [31:0]   w_pc_next;
    logic          w_pc_we;
    logic          w_flush_front;
    logic          w_flush_ex;
    redirect_src_e w_src;
    logic          w_start;
    logic          w_abort;
    logic          w_resume_wr;
    fence_state_e  w_fstate;
    logic          w_fbusy;
    logic          w_ftimeout;

    assign w_stall    = bus.stall_fetch;
    assign w_late     = bus.trap_valid | bus.mispredict_valid | bus.branch_valid;
    assign w_seq_pc   = seq_pc(bus.pc_cur);
    assign w_jump_tgt = bus.pc_cur + bus.jump_offset - 32'd4;

    always_comb begin
        w_late_tgt = bus.branch_target;
        w_late_src = SRC_BRANCH;
        if (bus.trap_valid) begin
            w_late_tgt = bus.trap_target;
            w_late_src = SRC_TRAP;
        end else if (bus.mispredict_valid) begin
            w_late_tgt = seq_pc(bus.mispredict_pc);
            w_late_src = SRC_MISPREDICT;
        end
    end

    always_comb begin
        w_pc_next     = w_seq_pc;
        w_pc_we       = !w_stall;
        w_flush_front = 1'b0;
        w_flush_ex    = 1'b0;
        w_src         = SRC_SEQ;
        w_start       = 1'b0;
        w_abort       = 1'b0;
        w_resume_wr   = 1'b0;
        if (rst) begin
            w_pc_next = RESET_VECTOR;
            w_pc_we   = 1'b0;
        end else if (w_late) begin
            w_pc_next     = w_late_tgt;
            w_flush_front = 1'b1;
            w_flush_ex    = 1'b1;
            w_src         = w_late_src;
            w_abort       = 1'b1;
        end else if (r_pend_valid) begin
            w_pc_next     = r_pend_target;
            w_flush_front = !w_stall;
            w_src         = SRC_PEND;
            w_abort       = 1'b1;
        end else if (bus.jump_valid && !w_stall) begin
            w_pc_next     = w_jump_tgt;
            w_flush_front = 1'b1;
            w_src         = SRC_JUMP;
            w_abort       = 1'b1;
        end else if (w_fstate == FENCE_DRAIN) begin
            w_pc_we = 1'b0;
        end else if (w_fstate == FENCE_RESUME) begin
            w_flush_front = 1'b1;
            w_src         = SRC_FENCE;
            w_resume_wr   = !w_stall;
        end else if (bus.fence_req && !bus.jump_valid) begin
            // a fence alongside a jump is on the wrong path and is dropped
            w_pc_we = 1'b0;
            w_start = 1'b1;
        end
    end

    // Only a trap may replace a redirect already parked behind a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (w_late) begin
            if (!w_stall) begin
                r_pend_valid <= 1'b0;
            end else if (!r_pend_valid || bus.trap_valid) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_late_tgt;
            end
        end else if (r_pend_valid && !w_stall) begin
            r_pend_valid <= 1'b0;
        end
    end

    pc_fence_seq #(.DRAIN_MAX(DRAIN_MAX)) u_fence (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_abort      (w_abort),
        .i_pipe_empty (bus.pipe_empty),
        .i_resume_wr  (w_resume_wr),
        .o_state      (w_fstate),
        .o_busy       (w_fbusy),
        .o_timeout    (w_ftimeout)
    );

    assign bus.pc_next       = w_pc_next;
    assign bus.pc_we         = w_pc_we;
    assign bus.flush_front   = w_flush_front;
    assign bus.flush_ex      = w_flush_ex;
    assign bus.redirect_src  = w_src;
    assign bus.fence_busy    = w_fbusy && !rst;
    assign bus.fence_timeout = w_ftimeout && !rst;

`ifdef PC_REDIRECT_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_trap         <= '0;
            perf_mispredict   <= '0;
            perf_branch       <= '0;
            perf_jump         <= '0;
            perf_fence_cycles <= '0;
        end else begin
            if (w_pc_we && w_src == SRC_TRAP)       perf_trap       <= sat_inc(perf_trap);
            if (w_pc_we && w_src == SRC_MISPREDICT) perf_mispredict <= sat_inc(perf_mispredict);
            if (w_pc_we && w_src == SRC_BRANCH)     perf_branch     <= sat_inc(perf_branch);
            if (w_pc_we && w_src == SRC_JUMP)       perf_jump       <= sat_inc(perf_jump);
            if (w_fbusy) perf_fence_cycles <= sat_inc(perf_fence_cycles);
        end
    end
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios then random traffic,
// each cycle's expectation is queued by the driver and checked by a monitor.
module tb_pc_redirect_ctrl;
    import pc_redirect_ctrl_pkg::*;

    localparam int EW = 40;
    localparam logic [31:0] RV = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    pc_redirect_ctrl_if bus();

    pc_redirect_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // stimulus variables
    logic [1:0]  t_stall_code;
    logic        t_trap, t_misp, t_br, t_jump, t_fence, t_empty;
    logic [31:0] t_trap_tgt, t_misp_pc, t_br_tgt, t_jump_off;

    // reference state: what the front end should remember between cycles
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_tgt;
    int          m_phase;    // 0 normal, 1 draining, 2 waiting to restart
    int          m_drained;  // drain cycles elapsed in the current fence

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic clear_inputs();
        t_stall_code = 2'b00;
        {t_trap, t_misp, t_br, t_jump, t_fence, t_empty} = '0;
        t_trap_tgt = '0; t_misp_pc = '0; t_br_tgt = '0; t_jump_off = '0;
    endtask

    // Apply inputs, predict this cycle's outputs, advance the model, wait a clock.
    task automatic step();
        logic        stall, late, we, ff, fe, busy, tmo;
        logic [31:0] nxt, tgt;
        logic [2:0]  src;
        stall = |(t_stall_code & (STALL_EARLY | STALL_MMU));
        bus.pc_cur = m_pc;            bus.stall_fetch = stall;
        bus.trap_valid = t_trap;      bus.trap_target = t_trap_tgt;
        bus.mispredict_valid = t_misp; bus.mispredict_pc = t_misp_pc;
        bus.branch_valid = t_br;      bus.branch_target = t_br_tgt;
        bus.jump_valid = t_jump;      bus.jump_offset = t_jump_off;
        bus.fence_req = t_fence;      bus.pipe_empty = t_empty;

        nxt = m_pc + 32'd4; we = !stall; ff = 0; fe = 0; tmo = 0; src = 3'd0;
        busy = (m_phase == 1) && !rst;
        late = t_trap | t_misp | t_br;
        if (rst) begin
            nxt = RV; we = 0;
            m_pend = 0; m_phase = 0;
        end else if (late) begin
            tgt = t_trap ? t_trap_tgt : t_misp ? t_misp_pc + 32'd4 : t_br_tgt;
            src = t_trap ? 3'd1 : t_misp ? 3'd2 : 3'd3;
            nxt = tgt; ff = 1; fe = 1; m_phase = 0;
            if (!stall) m_pend = 0;
            else if (!m_pend || t_trap) begin m_pend = 1; m_pend_tgt = tgt; end
        end else if (m_pend) begin
            nxt = m_pend_tgt; src = 3'd6;
            if (!stall) begin ff = 1; m_pend = 0; end
        end else if (t_jump && !stall) begin
            nxt = m_pc + t_jump_off - 32'd4; ff = 1; src = 3'd4; m_phase = 0;
        end else if (m_phase == 1) begin
            we = 0; m_drained++;
            if (t_empty) m_phase = 2;
            else if (m_drained == DRAIN_MAX_DEF) begin tmo = 1; m_phase = 2; end
        end else if (m_phase == 2) begin
            ff = 1; src = 3'd5;
            if (!stall) m_phase = 0;
        end else if (t_fence && !t_jump) begin
            we = 0; m_phase = 1; m_drained = 0;
        end
        exp_q.push_back({nxt, we, ff, fe, busy, tmo, src});
        if (rst) m_pc = RV;
        else if (we) m_pc = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // monitor: one expectation per cycle, sampled mid-cycle
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_we",         {31'd0, bus.pc_we},         {31'd0, e[7]});
                chk("flush_front",   {31'd0, bus.flush_front},   {31'd0, e[6]});
                chk("flush_ex",      {31'd0, bus.flush_ex},      {31'd0, e[5]});
                chk("fence_busy",    {31'd0, bus.fence_busy},    {31'd0, e[4]});
                chk("fence_timeout", {31'd0, bus.fence_timeout}, {31'd0, e[3]});
                if (e[7] || e[6] || rst) begin
                    chk("pc_next",      bus.pc_next,               e[39:8]);
                    chk("redirect_src", {29'd0, bus.redirect_src}, {29'd0, e[2:0]});
                end
            end
        end
    end

    initial begin
        clear_inputs();
        rst = 1'b1; m_pc = RV; m_pend = 0; m_pend_tgt = '0; m_phase = 0; m_drained = 0;
        @(posedge clk); #1;
        // reset held two cycles, then sequential from the reset vector
        step(); step();
        rst = 1'b0;
        idle_steps(2);

        // trap and jump together: trap wins
        clear_inputs();
        t_trap = 1; t_trap_tgt = 32'h8000_1000; t_jump = 1; t_jump_off = 32'h10;
        step();
        idle_steps(1);

        // mispredict parked behind a 3-cycle stall
        clear_inputs();
        t_misp = 1; t_misp_pc = 32'h8000_0040; t_stall_code = STALL_MMU;
        step();
        t_misp = 0; step(); step();
        t_stall_code = 2'b00; step();
        idle_steps(1);

        // early jump backwards
        m_pc = 32'h8000_0010;
        clear_inputs();
        t_jump = 1; t_jump_off = 32'hFFFF_FFF8;
        step();
        idle_steps(1);

        // fence drain ending when the pipeline empties on the fifth drain cycle
        clear_inputs(); t_fence = 1; step();
        t_fence = 0;
        for (int i = 0; i < 5; i++) begin t_empty = (i == 4); step(); end
        idle_steps(2);

        // fence drain that times out
        clear_inputs(); t_fence = 1; step();
        t_fence = 0;
        for (int i = 0; i < 66; i++) step();
        idle_steps(1);

        // trap on the third drain cycle
        clear_inputs(); t_fence = 1; step();
        t_fence = 0; step(); step();
        t_trap = 1; t_trap_tgt = 32'h8000_2000; step();
        idle_steps(2);

        // stalled fence restart
        clear_inputs(); t_fence = 1; step();
        t_fence = 0; t_empty = 1; step();
        t_empty = 0; t_stall_code = STALL_EARLY; step(); step();
        idle_steps(2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            t_stall_code = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
            t_trap  = ($urandom_range(0, 19) == 0);
            t_misp  = ($urandom_range(0, 19) == 0);
            t_br    = ($urandom_range(0, 14) == 0);
            t_jump  = ($urandom_range(0, 9) == 0);
            t_fence = ($urandom_range(0, 14) == 0);
            t_empty = ($urandom_range(0, 3) == 0);
            t_trap_tgt = $urandom & 32'hFFFF_FFFC;
            t_misp_pc  = $urandom & 32'hFFFF_FFFC;
            t_br_tgt   = $urandom & 32'hFFFF_FFFC;
            t_jump_off = 32'($signed(int'($urandom_range(0, 512)) - 256)) << 2;
            step();
        end
        idle_steps(2);

        @(negedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
